// File: rtl/usb_tx_cu_if.sv
`default_nettype none
// ============================================================================
// usb_tx_cu_if : request, buffer and serializer signals of the USB TX control unit
// Revision 1.0
// ============================================================================
interface usb_tx_cu_if;
    logic       tx_start;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ready;
    logic       send_eop;
    logic       eop_done;
    logic       tx_transfer_active;
    logic       tx_error;

    modport master (
        output tx_start, tx_packet, buffer_occupancy, tx_packet_data,
               tx_byte_ready, eop_done,
        input  get_tx_packet_data, tx_byte, tx_byte_valid, send_eop,
               tx_transfer_active, tx_error
    );

    modport slave (
        input  tx_start, tx_packet, buffer_occupancy, tx_packet_data,
               tx_byte_ready, eop_done,
        output get_tx_packet_data, tx_byte, tx_byte_valid, send_eop,
               tx_transfer_active, tx_error
    );
endinterface
`default_nettype wire

// File: rtl/usb_tx_cu.sv
`default_nettype none
// ============================================================================
// usb_tx_cu : USB full-speed transmit sequencer (SYNC, PID, payload, CRC16, EOP)
// Revision 1.0
// ============================================================================
module usb_tx_cu #(
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] SYNC_BYTE   = 8'h80
) (
    input  logic       clk,
    input  logic       n_rst,
    usb_tx_cu_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_FETCH, S_FWAIT, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
    } state_t;

    localparam logic [7:0]  c_max_payload = 8'(MAX_PAYLOAD);
    localparam logic [15:0] c_crc_init    = 16'hFFFF;
    localparam logic [15:0] c_crc_poly    = 16'hA001;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_pid;
    logic [6:0]  r_count;
    logic [15:0] r_crc;
    logic [7:0]  r_data;
    logic        r_error;

    logic        w_req_is_data;
    logic        w_req_legal;
    logic        w_accept;
    logic        w_reject;
    logic        w_pid_is_data;
    logic        w_valid;
    logic        w_xfer;
    logic        w_get;
    logic        w_eop;
    logic [7:0]  w_byte;
    logic [7:0]  w_pid_code;

    // Reflected USB CRC16, whole byte folded in one cycle
    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ c_crc_poly;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign w_req_is_data = (bus.tx_packet == 3'd1) || (bus.tx_packet == 3'd2);
    assign w_req_legal   = (bus.tx_packet >= 3'd1) && (bus.tx_packet <= 3'd5) &&
                           !(w_req_is_data && ({1'b0, bus.buffer_occupancy} > c_max_payload));
    assign w_accept      = (r_state == S_IDLE) && bus.tx_start && w_req_legal;
    assign w_reject      = (r_state == S_IDLE) && bus.tx_start && !w_req_legal;
    assign w_pid_is_data = (r_pid == 3'd1) || (r_pid == 3'd2);
    assign w_xfer        = w_valid && bus.tx_byte_ready;

    always_comb begin
        w_pid_code = 8'h1E;
        case (r_pid)
            3'd1:    w_pid_code = 8'hC3;
            3'd2:    w_pid_code = 8'h4B;
            3'd3:    w_pid_code = 8'hD2;
            3'd4:    w_pid_code = 8'h5A;
            default: w_pid_code = 8'h1E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        w_byte  = 8'h00;
        w_get   = 1'b0;
        w_eop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_SYNC;
            end
            S_SYNC: begin
                w_valid = 1'b1;
                w_byte  = SYNC_BYTE;
                if (w_xfer) w_next = S_PID;
            end
            S_PID: begin
                w_valid = 1'b1;
                w_byte  = w_pid_code;
                if (w_xfer) begin
                    if (!w_pid_is_data)      w_next = S_EOP;
                    else if (r_count != '0)  w_next = S_FETCH;
                    else                     w_next = S_CRC_LO;
                end
            end
            S_FETCH: begin
                w_get  = 1'b1;
                w_next = S_FWAIT;
            end
            S_FWAIT: begin
                w_next = S_DATA;
            end
            S_DATA: begin
                w_valid = 1'b1;
                w_byte  = r_data;
                if (w_xfer) w_next = (r_count == 7'd1) ? S_CRC_LO : S_FETCH;
            end
            S_CRC_LO: begin
                w_valid = 1'b1;
                w_byte  = ~r_crc[7:0];
                if (w_xfer) w_next = S_CRC_HI;
            end
            S_CRC_HI: begin
                w_valid = 1'b1;
                w_byte  = ~r_crc[15:8];
                if (w_xfer) w_next = S_EOP;
            end
            S_EOP: begin
                w_eop = 1'b1;
                if (bus.eop_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_pid   <= 3'd0;
            r_count <= 7'd0;
            r_crc   <= c_crc_init;
            r_data  <= 8'h00;
            r_error <= 1'b0;
        end else begin
            r_error <= w_reject;
            if (w_accept) begin
                r_pid   <= bus.tx_packet;
                r_count <= w_req_is_data ? bus.buffer_occupancy : 7'd0;
                r_crc   <= c_crc_init;
            end
            if (r_state == S_FWAIT) r_data <= bus.tx_packet_data;
            if ((r_state == S_DATA) && w_xfer) begin
                r_crc   <= f_crc16_byte(r_crc, r_data);
                r_count <= r_count - 7'd1;
            end
        end
    end

    assign bus.tx_byte            = w_byte;
    assign bus.tx_byte_valid      = w_valid;
    assign bus.get_tx_packet_data = w_get;
    assign bus.send_eop           = w_eop;
    assign bus.tx_transfer_active = (r_state != S_IDLE);
    assign bus.tx_error           = r_error;
endmodule
`default_nettype wire
